// File: rtl/axil_cmd_sequencer_pkg.sv
// rtl/axil_cmd_sequencer_pkg.sv - shared op/status types and FSM state codes for the command sequencer
package axil_cmd_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_POLL  = 2'b10,
      OP_RMW   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      STAT_OK      = 2'b00,
      STAT_AXI_ERR = 2'b01,
      STAT_TIMEOUT = 2'b10
   } status_e;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WR_REQ   = 3'd1;
   localparam logic [2:0] S_WR_WAIT  = 3'd2;
   localparam logic [2:0] S_RD_REQ   = 3'd3;
   localparam logic [2:0] S_RD_WAIT  = 3'd4;
   localparam logic [2:0] S_POLL_GAP = 3'd5;
   localparam logic [2:0] S_RSP      = 3'd6;

endpackage

// File: rtl/axil_cmd_sequencer_if.sv
// rtl/axil_cmd_sequencer_if.sv - request/done bus between the sequencer and the AXI-Lite master
interface axil_cmd_sequencer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_done;
   logic [1:0]    wr_error;

   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_done;
   logic [1:0]    rd_error;

   modport master (
      output wr_valid, wr_addr, wr_data,
      input  wr_ready, wr_done, wr_error,
      output rd_valid, rd_addr,
      input  rd_ready, rd_data, rd_done, rd_error
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      output wr_ready, wr_done, wr_error,
      input  rd_valid, rd_addr,
      output rd_ready, rd_data, rd_done, rd_error
   );
endinterface

// File: rtl/axil_cmd_sequencer.sv
// rtl/axil_cmd_sequencer.sv - runs WRITE/READ/POLL/RMW commands as single-outstanding master accesses
module axil_cmd_sequencer
   import axil_cmd_sequencer_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int POLL_CNT_W     = 16,
   parameter int POLL_GAP       = 4
) (
   input  logic                      aclk_i,
   input  logic                      aresetn_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [1:0]                cmd_op_i,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0] cmd_data_i,
   input  logic [AXI_DATA_WIDTH-1:0] cmd_mask_i,
   input  logic [POLL_CNT_W-1:0]     cmd_timeout_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [AXI_DATA_WIDTH-1:0] rsp_data_o,
   output logic [1:0]                rsp_resp_o,
   output logic [1:0]                rsp_status_o,
   output logic                      busy_o,
   axil_cmd_sequencer_if.master      m_axil
);
   localparam int DW       = AXI_DATA_WIDTH;
   localparam int AW       = AXI_ADDR_WIDTH;
   localparam int PCW      = POLL_CNT_W;
   localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
   localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

   logic [2:0]       state_q, state_d;
   op_e              op_q, op_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    data_q, data_d;
   logic [DW-1:0]    mask_q, mask_d;
   logic [PCW-1:0]   timeout_q, timeout_d;
   logic [PCW-1:0]   attempts_q, attempts_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_resp_q, rsp_resp_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic             wr_fin, rd_eval, poll_hit;

   assign poll_hit = ((m_axil.rd_data & mask_q) == (data_q & mask_q));

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      data_d       = data_q;
      mask_d       = mask_q;
      timeout_d    = timeout_q;
      attempts_d   = attempts_q;
      gap_d        = gap_q;
      wr_data_d    = wr_data_q;
      rsp_data_d   = rsp_data_q;
      rsp_resp_d   = rsp_resp_q;
      rsp_status_d = rsp_status_q;
      wr_fin       = 1'b0;
      rd_eval      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               op_d       = op_e'(cmd_op_i);
               addr_d     = cmd_addr_i;
               data_d     = cmd_data_i;
               mask_d     = cmd_mask_i;
               timeout_d  = cmd_timeout_i;
               attempts_d = '0;
               wr_data_d  = cmd_data_i;
               state_d    = (op_e'(cmd_op_i) == OP_WRITE) ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (m_axil.wr_ready) begin
               if (m_axil.wr_done) wr_fin = 1'b1;
               else                state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: wr_fin = m_axil.wr_done;
         S_RD_REQ: begin
            if (m_axil.rd_ready) begin
               if (m_axil.rd_done) rd_eval = 1'b1;
               else                state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: rd_eval = m_axil.rd_done;
         S_POLL_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_W'(GAP_LAST)) state_d = S_RD_REQ;
         end
         S_RSP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_fin) begin
         rsp_data_d   = wr_data_q;
         rsp_resp_d   = m_axil.wr_error;
         rsp_status_d = (m_axil.wr_error != 2'b00) ? STAT_AXI_ERR : STAT_OK;
         state_d      = S_RSP;
      end

      // A failed read always ends the command, so an RMW never writes back stale data.
      if (rd_eval) begin
         rsp_data_d   = m_axil.rd_data;
         rsp_resp_d   = m_axil.rd_error;
         rsp_status_d = STAT_OK;
         state_d      = S_RSP;
         if (m_axil.rd_error != 2'b00) begin
            rsp_status_d = STAT_AXI_ERR;
         end else if (op_q == OP_RMW) begin
            wr_data_d = (m_axil.rd_data & ~mask_q) | (data_q & mask_q);
            state_d   = S_WR_REQ;
         end else if (op_q == OP_POLL && !poll_hit) begin
            if (attempts_q == timeout_q) begin
               rsp_status_d = STAT_TIMEOUT;
            end else begin
               attempts_d = attempts_q + 1'b1;
               gap_d      = '0;
               state_d    = (POLL_GAP == 0) ? S_RD_REQ : S_POLL_GAP;
            end
         end
      end
   end

   always_ff @(posedge aclk_i) begin
      if (!aresetn_i) begin
         state_q      <= S_IDLE;
         op_q         <= OP_WRITE;
         addr_q       <= '0;
         data_q       <= '0;
         mask_q       <= '0;
         timeout_q    <= '0;
         attempts_q   <= '0;
         gap_q        <= '0;
         wr_data_q    <= '0;
         rsp_data_q   <= '0;
         rsp_resp_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         mask_q       <= mask_d;
         timeout_q    <= timeout_d;
         attempts_q   <= attempts_d;
         gap_q        <= gap_d;
         wr_data_q    <= wr_data_d;
         rsp_data_q   <= rsp_data_d;
         rsp_resp_q   <= rsp_resp_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign cmd_ready_o     = aresetn_i && (state_q == S_IDLE);
   assign busy_o          = (state_q != S_IDLE);
   assign rsp_valid_o     = (state_q == S_RSP);
   assign rsp_data_o      = rsp_data_q;
   assign rsp_resp_o      = rsp_resp_q;
   assign rsp_status_o    = rsp_status_q;
   assign m_axil.wr_valid = (state_q == S_WR_REQ);
   assign m_axil.wr_addr  = addr_q;
   assign m_axil.wr_data  = wr_data_q;
   assign m_axil.rd_valid = (state_q == S_RD_REQ);
   assign m_axil.rd_addr  = addr_q;

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// tb/tb_axil_cmd_sequencer.sv - directed table, random commands vs reference model, latency and reset sequences
module tb_axil_cmd_sequencer;
   import axil_cmd_sequencer_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int PCW = 4;
   localparam int GAP = 2;

   logic           clk;
   logic           aresetn;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [1:0]     cmd_op;
   logic [AW-1:0]  cmd_addr;
   logic [DW-1:0]  cmd_data;
   logic [DW-1:0]  cmd_mask;
   logic [PCW-1:0] cmd_timeout;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [DW-1:0]  rsp_data;
   logic [1:0]     rsp_resp;
   logic [1:0]     rsp_status;
   logic           busy;

   axil_cmd_sequencer_if #(.AW(AW), .DW(DW)) bus ();

   axil_cmd_sequencer #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .POLL_CNT_W(PCW), .POLL_GAP(GAP)
   ) dut (
      .aclk_i(clk), .aresetn_i(aresetn),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
      .cmd_timeout_i(cmd_timeout),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .rsp_resp_o(rsp_resp), .rsp_status_o(rsp_status), .busy_o(busy),
      .m_axil(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];
   int ar_count = 0;
   int aw_count = 0;
   int poll_set_at = 0;
   int p_reads = 0;
   bit zero_wait = 1'b0;
   bit slow_rd = 1'b0;
   bit err_next = 1'b0;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Slave write channel: random ready delay, done in the ready cycle or up to two cycles later.
   initial begin
      int w_dly = 0;
      int w_cnt = 0;
      bus.wr_ready = 1'b0; bus.wr_done = 1'b0; bus.wr_error = 2'b00;
      forever begin
         @(negedge clk);
         bus.wr_ready = 1'b0;
         bus.wr_done  = 1'b0;
         if (!aresetn) begin
            w_cnt = 0; w_dly = 0;
         end else if (w_cnt > 0) begin
            w_cnt--;
            if (w_cnt == 0) bus.wr_done = 1'b1;
         end else if (bus.wr_valid) begin
            if (!zero_wait && w_dly > 0) begin
               w_dly--;
            end else begin
               bus.wr_ready = 1'b1;
               mem[bus.wr_addr] = bus.wr_data;
               aw_count++;
               w_cnt = zero_wait ? 0 : int'($urandom_range(0, 2));
               if (w_cnt == 0) bus.wr_done = 1'b1;
               w_dly = int'($urandom_range(0, 3));
            end
         end
      end
   end

   // Slave read channel, with optional SLVERR on the next read and bit0 of 0x20 set from read N on.
   initial begin
      int r_dly = 0;
      int r_cnt = 0;
      logic [31:0] val;
      logic [31:0] r_val;
      logic [1:0]  err;
      logic [1:0]  r_err;
      r_val = '0; r_err = '0;
      bus.rd_ready = 1'b0; bus.rd_done = 1'b0; bus.rd_error = 2'b00; bus.rd_data = '0;
      forever begin
         @(negedge clk);
         bus.rd_ready = 1'b0;
         bus.rd_done  = 1'b0;
         if (!aresetn) begin
            r_cnt = 0; r_dly = 0;
         end else if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin
               bus.rd_done = 1'b1; bus.rd_data = r_val; bus.rd_error = r_err;
            end
         end else if (bus.rd_valid) begin
            if (!zero_wait && r_dly > 0) begin
               r_dly--;
            end else begin
               bus.rd_ready = 1'b1;
               ar_count++;
               p_reads++;
               val = mem.exists(bus.rd_addr) ? mem[bus.rd_addr] : 32'h0;
               if (poll_set_at != 0 && bus.rd_addr == 32'h20 && p_reads >= poll_set_at) begin
                  val = val | 32'h1;
                  mem[bus.rd_addr] = val;
               end
               err = err_next ? 2'b10 : 2'b00;
               if (err_next) val = 32'h0;
               err_next = 1'b0;
               r_cnt = zero_wait ? 0 : (slow_rd ? 6 : int'($urandom_range(0, 2)));
               if (r_cnt == 0) begin
                  bus.rd_done = 1'b1; bus.rd_data = val; bus.rd_error = err;
               end else begin
                  r_val = val; r_err = err;
               end
               r_dly = int'($urandom_range(0, 3));
            end
         end
      end
   end

   task automatic model_cmd(input op_e op, input logic [31:0] addr, data, mask,
                            input int to, input int set_at, input bit err,
                            output logic [31:0] e_data, output logic [1:0] e_resp, e_status,
                            output int e_reads, e_writes);
      logic [31:0] v;
      e_reads = 0; e_writes = 0; e_resp = 2'b00; e_status = 2'b00; e_data = '0;
      case (op)
         OP_WRITE: begin
            model_mem[addr] = data; e_data = data; e_writes = 1;
         end
         OP_READ: begin
            e_reads = 1;
            if (err) begin e_resp = 2'b10; e_status = 2'b01; end
            else e_data = model_mem[addr];
         end
         OP_RMW: begin
            e_reads = 1;
            if (err) begin
               e_resp = 2'b10; e_status = 2'b01;
            end else begin
               e_data = (model_mem[addr] & ~mask) | (data & mask);
               model_mem[addr] = e_data;
               e_writes = 1;
            end
         end
         default: begin
            e_status = 2'b10;
            for (int n = 1; n <= to + 1; n++) begin
               e_reads = n;
               v = model_mem[addr];
               if (set_at != 0 && addr == 32'h20 && n >= set_at) begin
                  v = v | 32'h1;
                  model_mem[addr] = v;
               end
               if (n == 1 && err) begin
                  e_data = '0; e_resp = 2'b10; e_status = 2'b01;
                  break;
               end
               e_data = v;
               if ((v & mask) == (data & mask)) begin
                  e_status = 2'b00;
                  break;
               end
            end
         end
      endcase
   endtask

   task automatic run_cmd(input op_e op, input logic [31:0] addr, data, mask,
                          input int to, input int set_at, input bit err,
                          output logic [31:0] g_data, output logic [1:0] g_resp, g_status,
                          output int g_reads, g_writes);
      int ar0;
      int aw0;
      int budget;
      poll_set_at = set_at; p_reads = 0; err_next = err;
      ar0 = ar_count; aw0 = aw_count;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      cmd_mask = mask; cmd_timeout = PCW'(to);
      budget = 0;
      while (!cmd_ready && budget < 100) begin tick(); budget++; end
      tick();
      cmd_valid = 1'b0;
      budget = 0;
      while (!rsp_valid && budget < 3000) begin tick(); budget++; end
      if (!rsp_valid) begin
         n_total++;
         $display("FAIL rsp_timeout: no response within 3000 cycles");
         g_data = '1; g_resp = '1; g_status = '1; g_reads = -1; g_writes = -1;
         err_next = 1'b0;
         return;
      end
      repeat ($urandom_range(0, 2)) begin
         tick();
         check("rsp_held", rsp_valid, 1'b1);
      end
      g_data = rsp_data; g_resp = rsp_resp; g_status = rsp_status;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      g_reads = ar_count - ar0; g_writes = aw_count - aw0;
      err_next = 1'b0;
   endtask

   typedef struct {
      op_e         op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
      int          to;
      int          set_at;
      bit          err;
      logic [31:0] e_data;
      logic [1:0]  e_status;
      logic [1:0]  e_resp;
      int          e_reads;
      int          e_writes;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [31:0] g_data, m_data;
      logic [1:0]  g_resp, g_status, m_resp, m_status;
      int          g_reads, g_writes, m_reads, m_writes;
      logic [31:0] a, d, m;
      op_e         op;
      int          to, ar0, b;
      bit          err;

      aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      cmd_mask = '0; cmd_timeout = '0; rsp_ready = 1'b0;
      mem[32'h10] = 32'h0;         model_mem[32'h10] = 32'h0;
      mem[32'h20] = 32'hAAAA_AAA0; model_mem[32'h20] = 32'hAAAA_AAA0;
      mem[32'h30] = 32'h5;         model_mem[32'h30] = 32'h5;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         mem[32'h100 + 4*i] = d; model_mem[32'h100 + 4*i] = d;
      end

      tbl[0] = '{OP_WRITE, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 1};
      tbl[1] = '{OP_READ,  32'h10, 32'h0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 2'b00, 2'b00, 1, 0};
      tbl[2] = '{OP_RMW,   32'h10, 32'h0000_1200, 32'h0000_FF00, 0, 0, 1'b0, 32'hDEAD_12EF, 2'b00, 2'b00, 1, 1};
      tbl[3] = '{OP_READ,  32'h10, 32'h0, 32'h0, 0, 0, 1'b0, 32'hDEAD_12EF, 2'b00, 2'b00, 1, 0};
      tbl[4] = '{OP_POLL,  32'h20, 32'h1, 32'h1, 5, 0, 1'b0, 32'hAAAA_AAA0, 2'b10, 2'b00, 6, 0};
      tbl[5] = '{OP_POLL,  32'h20, 32'h1, 32'h1, 5, 3, 1'b0, 32'hAAAA_AAA1, 2'b00, 2'b00, 3, 0};
      tbl[6] = '{OP_RMW,   32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0, 2'b01, 2'b10, 1, 0};
      tbl[7] = '{OP_POLL,  32'h30, 32'h1, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h5, 2'b10, 2'b00, 1, 0};
      tbl[8] = '{OP_POLL,  32'h30, 32'h0, 32'hF, 15, 0, 1'b0, 32'h5, 2'b10, 2'b00, 16, 0};
      tbl[9] = '{OP_WRITE, 32'h10, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 32'h1234_5678, 2'b00, 2'b00, 0, 1};

      cmd_valid = 1'b1;
      repeat (3) tick();
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_wr_valid", bus.wr_valid, 1'b0);
      check("rst_rd_valid", bus.rd_valid, 1'b0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_wr_addr", bus.wr_addr, 32'h0);
      cmd_valid = 1'b0;
      aresetn = 1'b1;
      tick();
      check("idle_cmd_ready", cmd_ready, 1'b1);
      check("idle_busy", busy, 1'b0);

      for (int i = 0; i < 10; i++) begin
         run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].to, tbl[i].set_at,
                 tbl[i].err, g_data, g_resp, g_status, g_reads, g_writes);
         model_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].to, tbl[i].set_at,
                   tbl[i].err, m_data, m_resp, m_status, m_reads, m_writes);
         check($sformatf("v%0d_data", i), g_data, tbl[i].e_data);
         check($sformatf("v%0d_status", i), g_status, tbl[i].e_status);
         check($sformatf("v%0d_resp", i), g_resp, tbl[i].e_resp);
         check($sformatf("v%0d_reads", i), g_reads, tbl[i].e_reads);
         check($sformatf("v%0d_writes", i), g_writes, tbl[i].e_writes);
         if (i == 0) check("v0_slave_reg", mem[32'h10], 32'hDEAD_BEEF);
         if (i == 2) check("v2_slave_reg", mem[32'h10], 32'hDEAD_12EF);
      end

      zero_wait = 1'b1;
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 32'h40; cmd_data = 32'h11; cmd_mask = '0;
      tick();
      cmd_valid = 1'b0;
      check("lat_wr_valid", bus.wr_valid, 1'b1);
      check("lat_rsp_early", rsp_valid, 1'b0);
      tick();
      check("lat_rsp_valid", rsp_valid, 1'b1);
      check("lat_rsp_data", rsp_data, 32'h11);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("lat_cmd_ready", cmd_ready, 1'b1);
      check("lat_busy", busy, 1'b0);
      zero_wait = 1'b0;
      model_mem[32'h40] = 32'h11;

      for (int i = 0; i < 40; i++) begin
         op  = op_e'($urandom_range(0, 3));
         a   = 32'h100 + 4 * $urandom_range(0, 3);
         m   = $urandom;
         d   = $urandom_range(0, 1) ? model_mem[a] : $urandom;
         to  = int'($urandom_range(0, 3));
         err = (op != OP_WRITE) && ($urandom_range(0, 7) == 0);
         run_cmd(op, a, d, m, to, 0, err, g_data, g_resp, g_status, g_reads, g_writes);
         model_cmd(op, a, d, m, to, 0, err, m_data, m_resp, m_status, m_reads, m_writes);
         check($sformatf("r%0d_data", i), g_data, m_data);
         check($sformatf("r%0d_status", i), g_status, m_status);
         check($sformatf("r%0d_resp", i), g_resp, m_resp);
         check($sformatf("r%0d_reads", i), g_reads, m_reads);
         check($sformatf("r%0d_writes", i), g_writes, m_writes);
      end

      slow_rd = 1'b1;
      ar0 = ar_count;
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 32'h10;
      tick();
      cmd_valid = 1'b0;
      b = 0;
      while (ar_count == ar0 && b < 50) begin tick(); b++; end
      tick();
      check("mid_busy", busy, 1'b1);
      check("mid_rd_valid", bus.rd_valid, 1'b0);
      aresetn = 1'b0;
      tick();
      check("mid_rst_rd_valid", bus.rd_valid, 1'b0);
      check("mid_rst_wr_valid", bus.wr_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b0);
      tick();
      aresetn = 1'b1;
      slow_rd = 1'b0;
      tick();
      run_cmd(OP_WRITE, 32'h10, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0,
              g_data, g_resp, g_status, g_reads, g_writes);
      check("post_rst_status", g_status, 2'b00);
      check("post_rst_data", g_data, 32'hCAFE_F00D);
      check("post_rst_writes", g_writes, 1);
      check("post_rst_reg", mem[32'h10], 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
